// File: rtl/trig_tx_pkg.sv
// ---------------------------------------------------------------------------
// trig_tx_pkg
// Shared types and helpers for the coax trigger transmitter.
//   state_t    : transmitter state (IDLE, FIRE, HOLDOFF)
//   COAX_IDLE  : coax line level when no pulse is driven (high)
//   COAX_ACTIVE: coax line level during a trigger pulse (low)
//   sat_inc    : saturating increment of a counter of width w (w <= 64)
// ---------------------------------------------------------------------------
package trig_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic COAX_IDLE   = 1'b1;
    localparam logic COAX_ACTIVE = 1'b0;

    localparam int SAT_MAXW = 64;

    // Callers widen their counter to SAT_MAXW bits, pass their own width in w
    // and truncate the result back. The counter sticks at all-ones.
    function automatic logic [SAT_MAXW-1:0] sat_inc(input logic [SAT_MAXW-1:0] v,
                                                    input int w);
        logic [SAT_MAXW-1:0] top;
        top = (w >= SAT_MAXW) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/trig_mult_cmp.sv
// ---------------------------------------------------------------------------
// trig_mult_cmp
// Combinational multiplicity comparator: counts channels that are both active
// and enabled and compares the count against a threshold (0 acts as 1).
//   disc_r  in  NCH  per-channel active flags (already registered)
//   mask_r  in  NCH  1 = channel participates
//   mult_r  in  5    required multiplicity
//   mult_ok out 1    count >= max(mult_r, 1)
// ---------------------------------------------------------------------------
module trig_mult_cmp import trig_tx_pkg::*; #(
    parameter int NCH = 16
) (
    input  logic [NCH-1:0] disc_r,
    input  logic [NCH-1:0] mask_r,
    input  logic [4:0]     mult_r,
    output logic           mult_ok
);

    localparam int PCW = $clog2(NCH + 1);
    // At least 5 bits so the 5-bit threshold always fits beside the count.
    localparam int CW  = (PCW > 5) ? PCW : 5;

    logic [CW-1:0] hits;
    logic [4:0]    thr;

    always_comb begin
        hits = '0;
        for (int i = 0; i < NCH; i++) begin
            hits = hits + CW'(disc_r[i] & mask_r[i]);
        end
        thr     = (mult_r == 5'd0) ? 5'd1 : mult_r;
        mult_ok = (hits >= CW'(thr));
    end

endmodule

// File: rtl/coax_trig_tx.sv
// ---------------------------------------------------------------------------
// coax_trig_tx
// Board-side coax trigger transmitter. Forms a local trigger from masked
// discriminator multiplicity (rising edge only), applies a random prescale,
// and drives an active-low pulse of programmable length followed by a
// programmable dead time. force_trig bypasses multiplicity and prescale.
//   clk_adc     in   sample clock
//   rst         in   synchronous active-high reset
//   disc_in     in   per-channel over-threshold flags
//   chan_mask   in   channel participation mask
//   min_mult    in   multiplicity threshold (0 acts as 1)
//   pulse_len   in   pulse length in cycles (0 acts as 1)
//   holdoff_len in   dead cycles after the pulse
//   randnum     in   free-running random value
//   prescale    in   pass when randnum <= prescale
//   force_trig  in   forced/rolling trigger request
//   clr_cnt     in   synchronous counter clear
//   coax_out    out  coax drive, active low
//   trig_fired  out  one-cycle strobe when a pulse starts
//   busy        out  state is not IDLE
//   cnt_cand    out  accepted candidates
//   cnt_fired   out  pulses emitted
//   cnt_dead    out  candidates lost while busy
// ---------------------------------------------------------------------------
module coax_trig_tx import trig_tx_pkg::*; #(
    parameter int NCH  = 16,
    parameter int CNTW = 32,
    parameter int LENW = 8
) (
    input  logic            clk_adc,
    input  logic            rst,
    input  logic [NCH-1:0]  disc_in,
    input  logic [NCH-1:0]  chan_mask,
    input  logic [4:0]      min_mult,
    input  logic [LENW-1:0] pulse_len,
    input  logic [LENW-1:0] holdoff_len,
    input  logic [31:0]     randnum,
    input  logic [31:0]     prescale,
    input  logic            force_trig,
    input  logic            clr_cnt,
    output logic            coax_out,
    output logic            trig_fired,
    output logic            busy,
    output logic [CNTW-1:0] cnt_cand,
    output logic [CNTW-1:0] cnt_fired,
    output logic [CNTW-1:0] cnt_dead
);

    logic [NCH-1:0]  disc_r;
    logic [NCH-1:0]  mask_r;
    logic [4:0]      mult_r;
    logic [31:0]     randnum_r;
    logic [31:0]     prescale_r;

    logic            mult_ok;
    logic            mult_ok_d;
    logic            cand;
    logic            pass;
    logic            is_idle;
    logic            fire_go;
    logic [LENW-1:0] pulse_load;

    state_t          state;
    logic [LENW-1:0] tcnt;
    logic [LENW-1:0] hold_lat;

    // One register of retiming on everything that feeds the trigger decision.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            disc_r     <= '0;
            mask_r     <= '0;
            mult_r     <= '0;
            randnum_r  <= '0;
            prescale_r <= '0;
            mult_ok_d  <= 1'b1;  // blocks a candidate on the first cycle after reset
        end else begin
            disc_r     <= disc_in;
            mask_r     <= chan_mask;
            mult_r     <= min_mult;
            randnum_r  <= randnum;
            prescale_r <= prescale;
            mult_ok_d  <= mult_ok;
        end
    end

    trig_mult_cmp #(.NCH(NCH)) u_mult_cmp (
        .disc_r  (disc_r),
        .mask_r  (mask_r),
        .mult_r  (mult_r),
        .mult_ok (mult_ok)
    );

    always_comb begin
        cand       = mult_ok & ~mult_ok_d;
        pass       = (randnum_r <= prescale_r);
        is_idle    = (state == IDLE);
        fire_go    = is_idle & (force_trig | (cand & pass));
        pulse_load = (pulse_len == '0) ? '0 : (pulse_len - LENW'(1));
    end

    // tcnt holds remaining cycles minus one for the current FIRE/HOLDOFF phase.
    always_ff @(posedge clk_adc) begin
        if (rst) begin
            state      <= IDLE;
            tcnt       <= '0;
            hold_lat   <= '0;
            coax_out   <= COAX_IDLE;
            trig_fired <= 1'b0;
            busy       <= 1'b0;
        end else begin
            trig_fired <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire_go) begin
                        state      <= FIRE;
                        tcnt       <= pulse_load;
                        hold_lat   <= holdoff_len;
                        coax_out   <= COAX_ACTIVE;
                        trig_fired <= 1'b1;
                        busy       <= 1'b1;
                    end else if (cand && (holdoff_len != '0)) begin
                        // Prescaled-away candidate still costs a dead time.
                        state <= HOLDOFF;
                        tcnt  <= holdoff_len - LENW'(1);
                        busy  <= 1'b1;
                    end
                end
                FIRE: begin
                    if (tcnt == '0) begin
                        coax_out <= COAX_IDLE;
                        if (hold_lat == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= HOLDOFF;
                            tcnt  <= hold_lat - LENW'(1);
                        end
                    end else begin
                        tcnt <= tcnt - LENW'(1);
                    end
                end
                HOLDOFF: begin
                    if (tcnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tcnt <= tcnt - LENW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    coax_out <= COAX_IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Monitoring counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_adc) begin
        if (rst || clr_cnt) begin
            cnt_cand  <= '0;
            cnt_fired <= '0;
            cnt_dead  <= '0;
        end else begin
            if (cand && is_idle) begin
                cnt_cand <= CNTW'(sat_inc(SAT_MAXW'(cnt_cand), CNTW));
            end
            if (fire_go) begin
                cnt_fired <= CNTW'(sat_inc(SAT_MAXW'(cnt_fired), CNTW));
            end
            if (cand && !is_idle) begin
                cnt_dead <= CNTW'(sat_inc(SAT_MAXW'(cnt_dead), CNTW));
            end
        end
    end

endmodule

// File: doc/coax_trig_tx.md
Name: coax_trig_tx

Overview:
- Board-side transmitter for the coax trigger link. It forms a local trigger from per-channel discriminator flags using a channel mask and a multiplicity threshold, applies a random prescale, and drives one active-low coax line toward the trigger board.
- Pulse length and dead time are programmable. A forced/rolling request bypasses the trigger logic.
- Counters for candidates, fired triggers and dead-time losses are exported for slow-control readout.

Parameters:
- NCH, 16, number of discriminator channels.
- CNTW, 32, width of monitoring counters.
- LENW, 8, width of pulse_len and holdoff_len.

Ports:
- clk_adc  in  1  sample clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- disc_in  in  NCH  per-channel over-threshold flags.
- chan_mask  in  NCH  1 = channel participates.
- min_mult  in  5  required count of masked active channels; 0 is treated as 1.
- pulse_len  in  LENW  coax active-low length in cycles; 0 is treated as 1.
- holdoff_len  in  LENW  dead cycles after the pulse ends.
- randnum  in  32  free-running random value.
- prescale  in  32  pass when randnum <= prescale.
- force_trig  in  1  one-cycle forced/rolling request.
- clr_cnt  in  1  synchronous clear of counters.
- coax_out  out  1  coax drive, active low, idles 1.
- trig_fired  out  1  one-cycle strobe on FIRE entry.
- busy  out  1  1 when state is not IDLE.
- cnt_cand  out  CNTW  accepted multiplicity candidates.
- cnt_fired  out  CNTW  pulses emitted.
- cnt_dead  out  CNTW  candidates lost while busy.

Behaviour:
- Input stage, one register: disc_r, mask_r, mult_r, randnum_r and prescale_r are captured every cycle. The slow-clock config gets one cycle of retiming.
- mult_ok = popcount(disc_r & mask_r) >= max(mult_r, 1). This is combinational from the registered inputs.
- cand = mult_ok & ~mult_ok_d. It is rising-edge only, so a stuck input cannot retrigger. mult_ok_d resets to 1, which suppresses a spurious fire at reset release.
- pass = (randnum_r <= prescale_r).
- States: IDLE, FIRE, HOLDOFF. A down-counter tcnt is LENW bits wide.
- IDLE + force_trig:
  - go to FIRE and assert trig_fired; cnt_fired++.
  - mult and prescale are ignored.
  - If cand occurs in the same cycle, cnt_cand++ as well.
- IDLE + cand + pass: go to FIRE, trig_fired=1, cnt_cand++, cnt_fired++.
- IDLE + cand + !pass:
  - cnt_cand++ and go to HOLDOFF with no pulse, loading holdoff_len.
  - If holdoff_len==0, stay IDLE.
- FIRE entry:
  - tcnt loads max(pulse_len,1)-1.
  - pulse_len and holdoff_len are latched at this point; later changes do not affect the current trigger.
- FIRE: coax_out=0 for exactly max(pulse_len,1) cycles. When tcnt==0, go to HOLDOFF, or to IDLE if latched holdoff==0.
- HOLDOFF: coax_out=1 for exactly holdoff_len cycles, then IDLE.
- Candidate re-acceptance: a new candidate is accepted at the earliest on the first IDLE cycle.
- Busy-time losses:
  - cand while in FIRE or HOLDOFF: cnt_dead++ and the candidate is dropped.
  - force_trig while busy: dropped and not counted.
- Latency:
  - disc_in high before edge E0 → disc_r at E0 → state and coax_out registered at E1.
  - coax_out is low from E1, i.e. 2 edges after the input is presented.
  - trig_fired is high in the same cycle coax_out first goes low.
- Outputs: coax_out, trig_fired and busy are all registered, with no glitches.
- Counters:
  - They saturate at all-ones.
  - clr_cnt zeroes all three; clear wins over a simultaneous increment.
  - clr_cnt does not affect state.
- Reset:
  - state=IDLE, coax_out=1, trig_fired=0, busy=0, counters=0, tcnt=0, input registers=0, mult_ok_d=1.
  - Reset mid-pulse returns coax_out to 1 at the next edge.
- Receiver compatibility: the receiver stretches each pulse to 20 cycles and is dead for 20 cycles after firing. holdoff_len defaults to 20 in software.

Decomposition:
- Package trig_tx_pkg holds:
  - state enum {IDLE, FIRE, HOLDOFF};
  - COAX_IDLE = 1'b1 and COAX_ACTIVE = 1'b0;
  - a saturating-increment function, parameterised by CNTW.
- Sub-module trig_mult_cmp, purely combinational: inputs disc_r, mask_r, mult_r; output mult_ok. It is reused by the trigger-board coincidence logic.

Test Plan:
- Multiplicity gating:
  - Setup: mask=0x000F, min_mult=2, prescale=0xFFFFFFFF, pulse_len=4, holdoff_len=20.
  - disc_in=0x0003 for 1 cycle → coax_out low for exactly 4 cycles starting 2 edges later; trig_fired for 1 cycle; cnt_cand=1, cnt_fired=1.
- Mask and threshold:
  - disc_in=0x0030 with mask=0x000F → no pulse, cnt_cand=0.
  - min_mult=0 with disc_in=0x0001 → fires (treated as 1).
- Dead time:
  - Two single-cycle candidates 10 cycles apart with pulse 4, holdoff 20 → one pulse; cnt_dead=1.
  - A third candidate 25 cycles after the first → fires; cnt_fired=2.
- Prescale:
  - prescale=0, randnum=5 → candidate gives no pulse, busy for 20 cycles, cnt_cand=1, cnt_fired=0.
  - randnum=0 → fires.
- Stuck input and force:
  - disc_in held 0x0003 for 100 cycles → exactly one pulse.
  - force_trig in IDLE → pulse; cnt_cand unchanged.
  - force_trig during HOLDOFF → ignored.
- Reset and clear:
  - rst in the 2nd pulse cycle → coax_out=1 next edge, busy=0.
  - clr_cnt coincident with a fire → all counters read 0 afterwards.
  - Counter preloaded near all-ones (via force) saturates and does not wrap.
